cu_lsu_arbiter: RTL

//  Shares NUM_CHANNELS data-memory ports among NUM_THREADS per-thread LSUs inside a compute unit.

---
 rtl/cu_lsu_arbiter_if.sv | 41 ++++
 rtl/cu_lsu_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/cu_lsu_arbiter_if.sv
// Request/response bundle between per-thread LSUs, the arbiter and the CU data memory.
interface cu_lsu_arbiter_if #(
   parameter int unsigned NUM_THREADS     = 4,
   parameter int unsigned NUM_CHANNELS    = 1,
   parameter int unsigned DATA_WIDTH      = 16,
   parameter int unsigned DATA_ADDR_WIDTH = 8
);
   // thread side
   logic [NUM_THREADS-1:0]                 lsu_req_val;
   logic [NUM_THREADS-1:0]                 lsu_req_wen;
   logic [NUM_THREADS*DATA_ADDR_WIDTH-1:0] lsu_req_addr;
   logic [NUM_THREADS*DATA_WIDTH-1:0]      lsu_req_data;
   logic [NUM_THREADS-1:0]                 lsu_req_rdy;
   logic [NUM_THREADS-1:0]                 lsu_resp_val;
   logic [NUM_THREADS*DATA_WIDTH-1:0]      lsu_resp_data;

   // memory side
   logic [NUM_CHANNELS-1:0]                 mem_req_val;
   logic [NUM_CHANNELS-1:0]                 mem_req_rdy;
   logic [NUM_CHANNELS-1:0]                 mem_req_wen;
   logic [NUM_CHANNELS*DATA_ADDR_WIDTH-1:0] mem_req_addr;
   logic [NUM_CHANNELS*DATA_WIDTH-1:0]      mem_req_data;
   logic [NUM_CHANNELS-1:0]                 mem_resp_val;
   logic [NUM_CHANNELS*DATA_WIDTH-1:0]      mem_resp_data;

   // arbiter view
   modport slave (
      input  lsu_req_val, lsu_req_wen, lsu_req_addr, lsu_req_data,
      output lsu_req_rdy, lsu_resp_val, lsu_resp_data,
      output mem_req_val, mem_req_wen, mem_req_addr, mem_req_data,
      input  mem_req_rdy, mem_resp_val, mem_resp_data
   );

   // environment view (LSUs plus memory)
   modport master (
      output lsu_req_val, lsu_req_wen, lsu_req_addr, lsu_req_data,
      input  lsu_req_rdy, lsu_resp_val, lsu_resp_data,
      input  mem_req_val, mem_req_wen, mem_req_addr, mem_req_data,
      output mem_req_rdy, mem_resp_val, mem_resp_data
   );
endinterface

// File: rtl/cu_lsu_arbiter.sv
// Round-robin arbiter sharing NUM_CHANNELS data-memory ports among NUM_THREADS LSUs.
// Each channel carries one outstanding access and routes its response to the owner.
// Optional: define CU_LSU_ARB_PERF_EN to add the perf_stall_cycles counter output.
module cu_lsu_arbiter #(
   parameter int unsigned NUM_THREADS     = 4,
   parameter int unsigned NUM_CHANNELS    = 1,
   parameter int unsigned DATA_WIDTH      = 16,
   parameter int unsigned DATA_ADDR_WIDTH = 8
) (
   input  logic            clk,
   input  logic            reset,
   cu_lsu_arbiter_if.slave bus
`ifdef CU_LSU_ARB_PERF_EN
   ,
   output logic [31:0]     perf_stall_cycles
`endif
);

   localparam int unsigned TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t                     state_q     [NUM_CHANNELS];
   state_t                     state_d     [NUM_CHANNELS];
   logic [TW-1:0]              owner_q     [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0]    wen_q;
   logic [DATA_ADDR_WIDTH-1:0] addr_q      [NUM_CHANNELS];
   logic [DATA_WIDTH-1:0]      data_q      [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0]    ch_grant;
   logic [TW-1:0]              ch_thread   [NUM_CHANNELS];
   logic [DATA_WIDTH-1:0]      mem_rdata   [NUM_CHANNELS];

   logic [NUM_THREADS-1:0]     busy_q;
   logic [NUM_THREADS-1:0]     busy_clr;
   logic [NUM_THREADS-1:0]     taken;
   logic [NUM_THREADS-1:0]     eligible;
   logic [NUM_THREADS-1:0]     resp_val_q;
   logic [NUM_THREADS-1:0]     resp_val_d;
   logic [DATA_WIDTH-1:0]      resp_data_q [NUM_THREADS];
   logic [DATA_WIDTH-1:0]      resp_data_d [NUM_THREADS];
   logic [DATA_ADDR_WIDTH-1:0] req_addr    [NUM_THREADS];
   logic [DATA_WIDTH-1:0]      req_data    [NUM_THREADS];
   logic [TW-1:0]              rr_q;
   logic [TW-1:0]              rr_d;

   // unpack per-thread request fields and pack per-thread responses
   for (genvar gt = 0; gt < NUM_THREADS; gt++) begin : g_thread
      assign req_addr[gt] = bus.lsu_req_addr[gt*DATA_ADDR_WIDTH +: DATA_ADDR_WIDTH];
      assign req_data[gt] = bus.lsu_req_data[gt*DATA_WIDTH +: DATA_WIDTH];
      assign bus.lsu_resp_data[gt*DATA_WIDTH +: DATA_WIDTH] = resp_data_q[gt];
   end

   // per-channel memory request fields come straight from the channel registers
   for (genvar gc = 0; gc < NUM_CHANNELS; gc++) begin : g_chan
      assign mem_rdata[gc] = bus.mem_resp_data[gc*DATA_WIDTH +: DATA_WIDTH];
      assign bus.mem_req_val[gc] = (state_q[gc] == ST_REQ);
      assign bus.mem_req_addr[gc*DATA_ADDR_WIDTH +: DATA_ADDR_WIDTH] = addr_q[gc];
      assign bus.mem_req_data[gc*DATA_WIDTH +: DATA_WIDTH] = data_q[gc];
   end

   assign bus.mem_req_wen  = wen_q;
   assign bus.lsu_req_rdy  = taken;
   assign bus.lsu_resp_val = resp_val_q;
   assign eligible         = bus.lsu_req_val & ~busy_q;

   // grant search, channel next-state and response routing
   always_comb begin
      int unsigned idx;
      int unsigned nxt;
      idx        = 0;
      nxt        = 0;
      state_d    = state_q;
      ch_grant   = '0;
      taken      = '0;
      busy_clr   = '0;
      resp_val_d = '0;
      rr_d       = rr_q;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) ch_thread[c] = '0;
      for (int unsigned t = 0; t < NUM_THREADS; t++) resp_data_d[t] = resp_data_q[t];

      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
         case (state_q[c])
            ST_IDLE: begin
               if (!reset) begin
                  for (int unsigned k = 0; k < NUM_THREADS; k++) begin
                     idx = 32'(rr_q) + k;
                     if (idx >= NUM_THREADS) idx = idx - NUM_THREADS;
                     if (!ch_grant[c] && eligible[TW'(idx)] && !taken[TW'(idx)]) begin
                        ch_grant[c]     = 1'b1;
                        ch_thread[c]    = TW'(idx);
                        taken[TW'(idx)] = 1'b1;
                        nxt = idx + 1;
                        if (nxt >= NUM_THREADS) nxt = 0;
                        rr_d = TW'(nxt);
                     end
                  end
               end
               if (ch_grant[c]) state_d[c] = ST_REQ;
            end
            ST_REQ: begin
               if (bus.mem_req_rdy[c]) state_d[c] = ST_WAIT;
            end
            ST_WAIT: begin
               if (bus.mem_resp_val[c]) begin
                  state_d[c]                = ST_IDLE;
                  resp_val_d[owner_q[c]]    = 1'b1;
                  resp_data_d[owner_q[c]]   = wen_q[c] ? '0 : mem_rdata[c];
                  busy_clr[owner_q[c]]      = 1'b1;
               end
            end
            default: state_d[c] = ST_IDLE;
         endcase
      end
   end

   // channel state registers
   always_ff @(posedge clk) begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
         if (reset) state_q[c] <= ST_IDLE;
         else       state_q[c] <= state_d[c];
      end
   end

   // latch granted requests, track busy threads, pointer and responses
   always_ff @(posedge clk) begin
      if (reset) begin
         wen_q      <= '0;
         busy_q     <= '0;
         rr_q       <= '0;
         resp_val_q <= '0;
         for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            owner_q[c] <= '0;
            addr_q[c]  <= '0;
            data_q[c]  <= '0;
         end
         for (int unsigned t = 0; t < NUM_THREADS; t++) resp_data_q[t] <= '0;
      end else begin
         for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            if (ch_grant[c]) begin
               owner_q[c] <= ch_thread[c];
               wen_q[c]   <= bus.lsu_req_wen[ch_thread[c]];
               addr_q[c]  <= req_addr[ch_thread[c]];
               data_q[c]  <= req_data[ch_thread[c]];
            end
         end
         busy_q     <= (busy_q & ~busy_clr) | taken;
         rr_q       <= rr_d;
         resp_val_q <= resp_val_d;
         for (int unsigned t = 0; t < NUM_THREADS; t++) resp_data_q[t] <= resp_data_d[t];
      end
   end

`ifdef CU_LSU_ARB_PERF_EN
   logic stall;
   assign stall = |(eligible & ~taken);

   // saturating count of cycles where a ready thread was left without a channel
   always_ff @(posedge clk) begin
      if (reset)                                        perf_stall_cycles <= '0;
      else if (stall && perf_stall_cycles != 32'hFFFF_FFFF) perf_stall_cycles <= perf_stall_cycles + 32'd1;
   end
`endif

endmodule
